// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the bus UART transmitter: register offsets, CTRL bits, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_uart_tx_pkg;

    // Word offsets decoded from addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // CTRL bit positions
    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_PARITY_EN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// Generic synchronous FIFO holding bytes queued for transmission.
// Latency: a pushed entry is visible at rdata_o right after the accepting edge; the head is read combinationally.
// Backpressure: push is ignored when full and pop when empty, both judged on the pre-edge level.
module bus_uart_tx_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8,
    localparam int PtrW = $clog2(Depth),
    localparam int LvlW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LvlW-1:0]  level_o
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [LvlW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == LvlW'(Depth));
    assign empty_o = (count == '0);
    assign level_o = count;
    assign rdata_o = mem[rd_ptr];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is not reset; only entries behind the write pointer are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the simple-system bus; optional parity bit under BUS_UART_TX_PARITY_EN.
// Latency: bus response one cycle after req_i; tx_o begins a frame on the 2nd edge after the accepting TXDATA write.
// Backpressure: none on the bus; a TXDATA write into a full FIFO is dropped and answered with err_o.
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter int          FifoDepth    = 8,
    parameter logic [15:0] ClkDivReset  = 16'd433,
    parameter int          AddressWidth = 32,
    parameter int          DataWidth    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
    output logic                    tx_o,
    output logic                    irq_o
);

    localparam int LvlW = $clog2(FifoDepth) + 1;

    logic [1:0]          reg_sel;
    logic [DataWidth-1:0] rd_word;
    logic                bus_err;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LvlW-1:0]     fifo_level;
    logic [7:0]          fifo_head;
    logic [15:0]         clkdiv;
    logic                tx_en;
    logic                irq_en;
    logic [2:0]          ctrl_bits;
    uart_tx_state_e      state;
    logic [15:0]         bit_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic                bit_end;
    logic                busy;
    logic                start_frame;
    logic                unused_bits;

    assign reg_sel     = addr_i[3:2];
    assign busy        = (state != IDLE);
    assign bit_end     = (bit_cnt == 16'd0);
    assign start_frame = tx_en && !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign fifo_pop    = start_frame;
    assign unused_bits = ^{addr_i[AddressWidth-1:4], addr_i[1:0], be_i[3:2], wdata_i[DataWidth-1:16]};

`ifdef BUS_UART_TX_PARITY_EN
    logic parity_en;
    logic parity_bit;
`endif

    // CTRL readback image; the parity enable only exists when the parity option is built in
    always_comb begin
        ctrl_bits = '0;
        ctrl_bits[CTRL_TX_EN]  = tx_en;
        ctrl_bits[CTRL_IRQ_EN] = irq_en;
`ifdef BUS_UART_TX_PARITY_EN
        ctrl_bits[CTRL_PARITY_EN] = parity_en;
`else
        ctrl_bits[CTRL_PARITY_EN] = 1'b0;
`endif
    end

    bus_uart_tx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (wdata_i[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Address decode: read data, error flag and FIFO push for the current request
    always_comb begin
        rd_word   = '0;
        bus_err   = 1'b0;
        fifo_push = 1'b0;
        if (req_i) begin
            case (reg_sel)
                REG_TXDATA: begin
                    if (!we_i) begin
                        bus_err = 1'b1;
                    end else if (be_i[0]) begin
                        if (fifo_full) bus_err   = 1'b1;
                        else           fifo_push = 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (we_i) bus_err = 1'b1;
                    else      rd_word = DataWidth'({16'h0, 8'(fifo_level), 5'h0, busy, fifo_empty, fifo_full});
                end
                REG_CLKDIV: if (!we_i) rd_word = DataWidth'({16'h0, clkdiv});
                default:    if (!we_i) rd_word = DataWidth'({29'h0, ctrl_bits});
            endcase
        end
    end

    // Bus response is always exactly one cycle after the request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rd_word;
            err_o    <= bus_err;
        end
    end

    // Software-writable CLKDIV and CTRL registers, byte-enable qualified
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clkdiv <= ClkDivReset;
            tx_en  <= 1'b0;
            irq_en <= 1'b0;
`ifdef BUS_UART_TX_PARITY_EN
            parity_en <= 1'b0;
`endif
        end else if (req_i && we_i) begin
            case (reg_sel)
                REG_CLKDIV: begin
                    if (be_i[0]) clkdiv[7:0]  <= wdata_i[7:0];
                    if (be_i[1]) clkdiv[15:8] <= wdata_i[15:8];
                end
                REG_CTRL: begin
                    if (be_i[0]) begin
                        tx_en  <= wdata_i[CTRL_TX_EN];
                        irq_en <= wdata_i[CTRL_IRQ_EN];
`ifdef BUS_UART_TX_PARITY_EN
                        parity_en <= wdata_i[CTRL_PARITY_EN];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Serializer: tx_o is registered from the current state, so the line trails the state by one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            tx_o    <= 1'b1;
            irq_o   <= 1'b0;
`ifdef BUS_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            irq_o <= irq_en && fifo_empty && (state == IDLE);
            case (state)
                START:   tx_o <= 1'b0;
                DATA:    tx_o <= shreg[0];
`ifdef BUS_UART_TX_PARITY_EN
                PARITY:  tx_o <= parity_bit;
`endif
                default: tx_o <= 1'b1;
            endcase
            if (start_frame) begin
                state   <= START;
                bit_cnt <= clkdiv;
                bit_idx <= 3'd0;
                shreg   <= fifo_head;
`ifdef BUS_UART_TX_PARITY_EN
                parity_bit <= ^fifo_head;
`endif
            end else if (state != IDLE) begin
                if (!bit_end) begin
                    bit_cnt <= bit_cnt - 16'd1;
                end else begin
                    bit_cnt <= clkdiv;
                    case (state)
                        START: state <= DATA;
                        DATA: begin
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
                                state <= parity_en ? PARITY : STOP;
`else
                                state <= STOP;
`endif
                            end
                        end
`ifdef BUS_UART_TX_PARITY_EN
                        PARITY:  state <= STOP;
`endif
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: bus accesses plus a line receiver that decodes tx_o frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_uart_tx;

    localparam int         DEPTH    = 8;
    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CLKDIV = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        req_i   = 1'b0;
    logic        we_i    = 1'b0;
    logic [3:0]  be_i    = 4'h0;
    logic [31:0] addr_i  = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        tx_o;
    logic        irq_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] b_rdata;
    logic        b_err;
    logic        b_rv;
    int          last_acc;

    // line receiver state and decoded frames
    int          mon_p     = 1;
    int          mon_nbits = 10;
    int          fs_q[$];
    logic [10:0] fb_q[$];
    bit          fst_q[$];
    bit          m_busy = 1'b0;
    int          m_cnt;
    int          m_start;
    logic [10:0] m_bits;
    bit          m_stable;

    bus_uart_tx #(
        .FifoDepth    (DEPTH),
        .ClkDivReset  (16'd433),
        .AddressWidth (32),
        .DataWidth    (32)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .tx_o     (tx_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Receiver: a frame starts at the first low sample and is nbits*period samples long
    always @(negedge clk_i) begin
        if (rst_i) begin
            m_busy = 1'b0;
        end else begin
            if (!m_busy && tx_o === 1'b0) begin
                m_busy   = 1'b1;
                m_cnt    = 0;
                m_bits   = '1;
                m_stable = 1'b1;
                m_start  = cyc;
            end
            if (m_busy) begin
                if (m_cnt % mon_p == 0) m_bits[m_cnt / mon_p] = tx_o;
                else if (tx_o !== m_bits[m_cnt / mon_p]) m_stable = 1'b0;
                m_cnt++;
                if (m_cnt == mon_p * mon_nbits) begin
                    fs_q.push_back(m_start);
                    fb_q.push_back(m_bits);
                    fst_q.push_back(m_stable);
                    m_busy = 1'b0;
                end
            end
        end
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] d, input bit with_par);
        logic [10:0] f;
        f    = 11'h7FF;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (with_par) f[9] = ^d;
        return f;
    endfunction

    function automatic logic [31:0] status_of(input int level, input bit busy);
        return (32'(level) << 8) | (busy ? 32'h4 : 32'h0) |
               ((level == 0) ? 32'h2 : 32'h0) | ((level == DEPTH) ? 32'h1 : 32'h0);
    endfunction

    function automatic void clear_frames();
        fs_q.delete();
        fb_q.delete();
        fst_q.delete();
    endfunction

    task automatic bus_xfer(input bit we, input logic [1:0] reg_idx, input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk_i);
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        wdata_i = wdata;
        addr_i  = ($urandom & 32'hFFFF_FFF0) | {28'h0, reg_idx, 2'b00};
        @(posedge clk_i);
        #1;
        b_rv     = rvalid_o;
        b_rdata  = rdata_o;
        b_err    = err_o;
        last_acc = cyc;
        req_i    = 1'b0;
        we_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx_o); end
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq_o); end
        tests++; if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin fails++;
            $display("FAIL reset_resp: got rvalid=%b err=%b rdata=%h want zeros", rvalid_o, err_o, rdata_o); end
        rst_i = 1'b0;
        clear_frames();
        bus_xfer(1'b0, A_STATUS, 32'h0, 4'hF);
        tests++; if (b_rv !== 1'b1 || b_err !== 1'b0 || b_rdata !== 32'h2) begin fails++;
            $display("FAIL reset_status: got rv=%b err=%b rdata=%h want rv=1 err=0 rdata=00000002", b_rv, b_err, b_rdata); end
        @(posedge clk_i); #1;
        tests++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL rvalid_single: got %b want 0", rvalid_o); end
        bus_xfer(1'b0, A_CLKDIV, 32'h0, 4'hF);
        tests++; if (b_rdata !== 32'd433) begin fails++; $display("FAIL reset_clkdiv: got %0d want 433", b_rdata); end
        tests++; if (tx_o !== 1'b1 || irq_o !== 1'b0 || fs_q.size() != 0) begin fails++;
            $display("FAIL reset_idle_line: got tx=%b irq=%b frames=%0d want 1 0 0", tx_o, irq_o, fs_q.size()); end
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        int div;
        int wcyc;
        for (int it = 0; it < 3; it++) begin
            d   = (it == 0) ? 8'h55 : 8'($urandom);
            div = (it == 0) ? 3 : int'($urandom_range(0, 4));
            mon_p = div + 1; mon_nbits = 10;
            bus_xfer(1'b1, A_CLKDIV, 32'(div), 4'hF);
            bus_xfer(1'b1, A_CTRL, 32'h1, 4'hF);
            clear_frames();
            bus_xfer(1'b1, A_TXDATA, {24'h0, d}, 4'h1);
            wcyc = last_acc;
            tests++; if (b_err !== 1'b0 || b_rdata !== 32'h0) begin fails++;
                $display("FAIL single_wr_resp: got err=%b rdata=%h want 0 0", b_err, b_rdata); end
            repeat (2) @(posedge clk_i);
            bus_xfer(1'b0, A_STATUS, 32'h0, 4'hF);
            tests++; if (b_rdata !== status_of(0, 1'b1)) begin fails++;
                $display("FAIL single_busy: got %h want %h", b_rdata, status_of(0, 1'b1)); end
            for (int i = 0; i < (div + 1) * 12 + 20 && fs_q.size() < 1; i++) @(posedge clk_i);
            tests++;
            if (fs_q.size() < 1) begin fails++; $display("FAIL single_timeout: got 0 frames want 1"); end
            else begin
                tests++; if (fs_q[0] - wcyc != 2) begin fails++;
                    $display("FAIL single_latency: got %0d want 2", fs_q[0] - wcyc); end
                tests++; if (fb_q[0] !== exp_frame(d, 1'b0) || !fst_q[0]) begin fails++;
                    $display("FAIL single_bits: got %b stable=%b want %b", fb_q[0], fst_q[0], exp_frame(d, 1'b0)); end
            end
            repeat (3) @(posedge clk_i);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] model_q[$];
        logic [7:0] d;
        bit exp_err;
        bus_xfer(1'b1, A_CTRL, 32'h0, 4'hF);
        bus_xfer(1'b1, A_CLKDIV, 32'h1, 4'hF);
        mon_p = 2; mon_nbits = 10;
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = 8'($urandom);
            exp_err = (model_q.size() >= DEPTH);
            bus_xfer(1'b1, A_TXDATA, {$urandom, d} >> 0, 4'h1);
            if (!exp_err) model_q.push_back(d);
            tests++; if (b_err !== exp_err) begin fails++;
                $display("FAIL full_err[%0d]: got %b want %b", i, b_err, exp_err); end
        end
        bus_xfer(1'b0, A_STATUS, 32'h0, 4'hF);
        tests++; if (b_rdata !== status_of(model_q.size(), 1'b0)) begin fails++;
            $display("FAIL full_status: got %h want %h", b_rdata, status_of(model_q.size(), 1'b0)); end
        clear_frames();
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < DEPTH * 20 + 60 && fs_q.size() < DEPTH; i++) @(posedge clk_i);
        tests++;
        if (fs_q.size() < DEPTH) begin fails++; $display("FAIL full_timeout: got %0d frames want %0d", fs_q.size(), DEPTH); end
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                tests++; if (fb_q[i] !== exp_frame(model_q[i], 1'b0) || !fst_q[i]) begin fails++;
                    $display("FAIL full_frame[%0d]: got %b want %b", i, fb_q[i], exp_frame(model_q[i], 1'b0)); end
                if (i > 0) begin
                    tests++; if (fs_q[i] - fs_q[i-1] != 20) begin fails++;
                        $display("FAIL full_gap[%0d]: got %0d want 20", i, fs_q[i] - fs_q[i-1]); end
                end
            end
        end
        repeat (4) @(posedge clk_i);
        bus_xfer(1'b0, A_STATUS, 32'h0, 4'hF);
        tests++; if (b_rdata !== status_of(0, 1'b0)) begin fails++;
            $display("FAIL full_drained: got %h want %h", b_rdata, status_of(0, 1'b0)); end
    endtask

    task automatic test_irq();
        int wcyc;
        int rise;
        bus_xfer(1'b1, A_CLKDIV, 32'h0, 4'hF);
        bus_xfer(1'b1, A_CTRL, 32'h3, 4'hF);
        mon_p = 1; mon_nbits = 10;
        repeat (2) @(posedge clk_i); #1;
        tests++; if (irq_o !== 1'b1) begin fails++; $display("FAIL irq_idle: got %b want 1", irq_o); end
        clear_frames();
        bus_xfer(1'b1, A_TXDATA, 32'hA5, 4'h1);
        wcyc = last_acc;
        @(posedge clk_i); #1;
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_drop: got %b want 0", irq_o); end
        rise = -1;
        for (int i = 0; i < 50 && rise < 0; i++) begin
            @(posedge clk_i); #1;
            if (irq_o === 1'b1) rise = cyc;
        end
        tests++; if (rise - wcyc != 12) begin fails++; $display("FAIL irq_rise: got %0d want 12", rise - wcyc); end
        tests++; if (fs_q.size() != 1 || fb_q[0] !== exp_frame(8'hA5, 1'b0)) begin fails++;
            $display("FAIL irq_frame: got frames=%0d bits=%b want 1 %b", fs_q.size(), fb_q.size() ? fb_q[0] : 11'h0, exp_frame(8'hA5, 1'b0)); end
    endtask

    task automatic test_tx_en_clear();
        logic [7:0] d[3];
        bus_xfer(1'b1, A_CTRL, 32'h0, 4'hF);
        bus_xfer(1'b1, A_CLKDIV, 32'h1, 4'hF);
        mon_p = 2; mon_nbits = 10;
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'($urandom);
            bus_xfer(1'b1, A_TXDATA, {24'h0, d[i]}, 4'h1);
        end
        clear_frames();
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'hF);
        repeat (4) @(posedge clk_i);
        bus_xfer(1'b1, A_CTRL, 32'h0, 4'hF);
        repeat (60) @(posedge clk_i);
        tests++; if (fs_q.size() != 1 || fb_q[0][8:1] !== d[0]) begin fails++;
            $display("FAIL txen_clear_frames: got %0d frames want 1 with byte %h", fs_q.size(), d[0]); end
        bus_xfer(1'b0, A_STATUS, 32'h0, 4'hF);
        tests++; if (b_rdata !== status_of(2, 1'b0)) begin fails++;
            $display("FAIL txen_clear_status: got %h want %h", b_rdata, status_of(2, 1'b0)); end
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 120 && fs_q.size() < 3; i++) @(posedge clk_i);
        tests++;
        if (fs_q.size() < 3) begin fails++; $display("FAIL txen_resume_timeout: got %0d frames want 3", fs_q.size()); end
        else begin
            tests++; if (fb_q[1][8:1] !== d[1] || fb_q[2][8:1] !== d[2] || fs_q[2] - fs_q[1] != 20) begin fails++;
                $display("FAIL txen_resume: got %h %h gap %0d want %h %h gap 20", fb_q[1][8:1], fb_q[2][8:1], fs_q[2] - fs_q[1], d[1], d[2]); end
        end
        repeat (4) @(posedge clk_i);
    endtask

    task automatic test_errors();
        logic [31:0] w;
        logic [2:0]  c;
        logic [31:0] exp_ctrl;
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'hF);
        clear_frames();
        bus_xfer(1'b0, A_TXDATA, 32'h0, 4'hF);
        tests++; if (b_rv !== 1'b1 || b_err !== 1'b1 || b_rdata !== 32'h0) begin fails++;
            $display("FAIL err_rd_txdata: got rv=%b err=%b rdata=%h want 1 1 0", b_rv, b_err, b_rdata); end
        bus_xfer(1'b1, A_STATUS, $urandom, 4'hF);
        tests++; if (b_err !== 1'b1 || b_rdata !== 32'h0) begin fails++;
            $display("FAIL err_wr_status: got err=%b rdata=%h want 1 0", b_err, b_rdata); end
        bus_xfer(1'b1, A_TXDATA, $urandom, 4'hE);
        tests++; if (b_err !== 1'b0) begin fails++; $display("FAIL err_txdata_nobe: got err=%b want 0", b_err); end
        repeat (3) @(posedge clk_i);
        bus_xfer(1'b0, A_STATUS, 32'h0, 4'hF);
        tests++; if (b_rdata !== status_of(0, 1'b0) || fs_q.size() != 0) begin fails++;
            $display("FAIL err_no_effect: got status=%h frames=%0d want %h 0", b_rdata, fs_q.size(), status_of(0, 1'b0)); end
        w = $urandom;
        bus_xfer(1'b1, A_CLKDIV, 32'h0000_1234, 4'hF);
        bus_xfer(1'b1, A_CLKDIV, w, 4'h2);
        bus_xfer(1'b0, A_CLKDIV, 32'h0, 4'hF);
        tests++; if (b_rdata !== {16'h0, w[15:8], 8'h34}) begin fails++;
            $display("FAIL clkdiv_be: got %h want %h", b_rdata, {16'h0, w[15:8], 8'h34}); end
        c = 3'($urandom) & 3'b110;
        bus_xfer(1'b1, A_CTRL, {29'h0, c}, 4'hF);
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'hF);
`ifdef BUS_UART_TX_PARITY_EN
        exp_ctrl = {29'h0, c};
`else
        exp_ctrl = {30'h0, c[1:0]};
`endif
        tests++; if (b_rdata !== exp_ctrl) begin fails++; $display("FAIL ctrl_rw: got %h want %h", b_rdata, exp_ctrl); end
        bus_xfer(1'b1, A_CTRL, 32'h0, 4'hF);
    endtask

`ifdef BUS_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d[2];
        d[0] = 8'h07;
        d[1] = 8'($urandom);
        bus_xfer(1'b1, A_CLKDIV, 32'h1, 4'hF);
        mon_p = 2; mon_nbits = 11;
        bus_xfer(1'b1, A_CTRL, 32'h5, 4'hF);
        for (int k = 0; k < 2; k++) begin
            clear_frames();
            bus_xfer(1'b1, A_TXDATA, {24'h0, d[k]}, 4'h1);
            for (int i = 0; i < 80 && fs_q.size() < 1; i++) @(posedge clk_i);
            tests++; if (fs_q.size() != 1 || fb_q[0] !== exp_frame(d[k], 1'b1) || !fst_q[0]) begin fails++;
                $display("FAIL parity_frame[%0d]: got %0d frames bits=%b want %b", k, fs_q.size(), fb_q.size() ? fb_q[0] : 11'h0, exp_frame(d[k], 1'b1)); end
            repeat (4) @(posedge clk_i);
        end
        bus_xfer(1'b1, A_CTRL, 32'h0, 4'hF);
        mon_nbits = 10;
    endtask
`endif

    task automatic test_reset_mid_frame();
        int wcyc;
        bus_xfer(1'b1, A_CLKDIV, 32'h3, 4'hF);
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'hF);
        mon_p = 4; mon_nbits = 10;
        clear_frames();
        bus_xfer(1'b1, A_TXDATA, 32'h00, 4'h1);
        wcyc = last_acc;
        bus_xfer(1'b1, A_TXDATA, 32'hFF, 4'h1);
        while (cyc < wcyc + 12) @(negedge clk_i);
        tests++; if (tx_o !== 1'b0) begin fails++; $display("FAIL midframe_low: got %b want 0", tx_o); end
        rst_i = 1'b1;
        #1;
        tests++; if (tx_o !== 1'b1) begin fails++; $display("FAIL midframe_async_tx: got %b want 1", tx_o); end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        bus_xfer(1'b0, A_STATUS, 32'h0, 4'hF);
        tests++; if (b_rdata !== status_of(0, 1'b0)) begin fails++;
            $display("FAIL midframe_status: got %h want %h", b_rdata, status_of(0, 1'b0)); end
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'hF);
        tests++; if (b_rdata !== 32'h0) begin fails++; $display("FAIL midframe_ctrl: got %h want 0", b_rdata); end
        repeat (50) @(posedge clk_i);
        tests++; if (fs_q.size() != 0 || tx_o !== 1'b1) begin fails++;
            $display("FAIL midframe_quiet: got frames=%0d tx=%b want 0 1", fs_q.size(), tx_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fifo_full();
        test_irq();
        test_tx_en_clear();
        test_errors();
`ifdef BUS_UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
